// File: rtl/pc_seq_pkg.sv
// Shared types and default vectors for the PC sequencer.
// Exception support is built only when PC_SEQ_EXCEPTION_EN is defined.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD,
    REDIRECT
  } pc_state_t;

  typedef enum logic [2:0] {
    CAUSE_SEQ,
    CAUSE_HOLD,
    CAUSE_BRANCH,
    CAUSE_JUMP,
    CAUSE_EXC,
    CAUSE_ERET
  } redirect_cause_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_4180;

endpackage

// File: rtl/pc_target_mux.sv
// Combinational next-PC priority select for the PC sequencer.
// Exception/eret sources are present only when PC_SEQ_EXCEPTION_EN is defined.
module pc_target_mux
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic [31:0]     pc,
  input  logic [31:0]     epc,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [31:0]     branch_target,
  input  logic            jump_enabled,
  input  logic [25:0]     jump_index,
  input  logic            exc_req,
  input  logic            eret,
  output logic [31:0]     next_pc,
  output redirect_cause_t cause,
  output logic            target_misaligned
);

  logic [31:0] pc_plus4;

  assign pc_plus4 = pc + 32'd4;

`ifndef PC_SEQ_EXCEPTION_EN
  logic unused_exc_inputs;
  assign unused_exc_inputs = exc_req ^ eret ^ (^epc);
`endif

  // Fixed-priority selection of the next fetch address and its cause.
  always_comb begin
    next_pc           = pc_plus4;
    cause             = CAUSE_SEQ;
    target_misaligned = 1'b0;
`ifdef PC_SEQ_EXCEPTION_EN
    if (exc_req) begin
      next_pc = EXC_VECTOR;
      cause   = CAUSE_EXC;
    end else if (eret) begin
      next_pc           = {epc[31:2], 2'b00};
      cause             = CAUSE_ERET;
      target_misaligned = |epc[1:0];
    end else
`endif
    if (branch_taken) begin
      next_pc           = {branch_target[31:2], 2'b00};
      cause             = CAUSE_BRANCH;
      target_misaligned = |branch_target[1:0];
    end else if (jump_enabled) begin
      next_pc = {pc_plus4[31:28], jump_index, 2'b00};
      cause   = CAUSE_JUMP;
    end else if (stall) begin
      next_pc = pc;
      cause   = CAUSE_HOLD;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: BOOT/RUN/HOLD/REDIRECT FSM with registered outputs.
// Define PC_SEQ_EXCEPTION_EN to build exception entry/return and the EPC register.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jumpEnabled,
  input  logic [25:0] jumpIndex,
  input  logic        excReq,
  input  logic        eret,
  output logic [31:0] pcValue,
  output logic        fetchValid,
  output logic        flush,
  output logic [31:0] epcValue,
  output logic        misaligned
);

  pc_state_t       state;
  logic [31:0]     next_pc;
  redirect_cause_t cause;
  logic            target_misaligned;
  logic [31:0]     epc_q;

  pc_target_mux #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_target_mux (
    .pc               (pcValue),
    .epc              (epc_q),
    .stall            (stall),
    .branch_taken     (branchTaken),
    .branch_target    (branchTarget),
    .jump_enabled     (jumpEnabled),
    .jump_index       (jumpIndex),
    .exc_req          (excReq),
    .eret             (eret),
    .next_pc          (next_pc),
    .cause            (cause),
    .target_misaligned(target_misaligned)
  );

`ifdef PC_SEQ_EXCEPTION_EN
  // Capture the faulting fetch address on exception entry; eret leaves it intact.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      epc_q <= '0;
    end else if (state != BOOT && cause == CAUSE_EXC) begin
      epc_q <= pcValue;
    end
  end
`else
  assign epc_q = '0;
`endif

  assign epcValue = epc_q;

  // Sequencer FSM: state, fetch address and status flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= BOOT;
      pcValue    <= RESET_VECTOR;
      fetchValid <= 1'b0;
      flush      <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state      <= RUN;
          pcValue    <= RESET_VECTOR;
          fetchValid <= 1'b1;
          flush      <= 1'b0;
        end
        default: begin
          if (target_misaligned) begin
            misaligned <= 1'b1;
          end
          case (cause)
            CAUSE_HOLD: begin
              state      <= HOLD;
              pcValue    <= next_pc;
              fetchValid <= 1'b0;
              flush      <= 1'b0;
            end
            CAUSE_SEQ: begin
              state      <= RUN;
              // Leaving HOLD refetches the held address rather than advancing.
              pcValue    <= (state == HOLD) ? pcValue : next_pc;
              fetchValid <= 1'b1;
              flush      <= 1'b0;
            end
            default: begin
              state      <= REDIRECT;
              pcValue    <= next_pc;
              fetchValid <= 1'b1;
              flush      <= 1'b1;
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer using an expected-output scoreboard queue.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jumpEnabled;
  logic [25:0] jumpIndex;
  logic        excReq;
  logic        eret;
  logic [31:0] pcValue;
  logic        fetchValid;
  logic        flush;
  logic [31:0] epcValue;
  logic        misaligned;

  typedef struct packed {
    logic [31:0] pc;
    logic        fv;
    logic        fl;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  pc_sequencer #(
    .RESET_VECTOR(32'h0000_3000),
    .EXC_VECTOR  (32'h0000_4180)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .branchTaken (branchTaken),
    .branchTarget(branchTarget),
    .jumpEnabled (jumpEnabled),
    .jumpIndex   (jumpIndex),
    .excReq      (excReq),
    .eret        (eret),
    .pcValue     (pcValue),
    .fetchValid  (fetchValid),
    .flush       (flush),
    .epcValue    (epcValue),
    .misaligned  (misaligned)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    stall        = 1'b0;
    branchTaken  = 1'b0;
    branchTarget = '0;
    jumpEnabled  = 1'b0;
    jumpIndex    = '0;
    excReq       = 1'b0;
    eret         = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    tick();
    tick();
    checks++;
    if ({pcValue, fetchValid, flush, epcValue, misaligned} !==
        {32'h0000_3000, 1'b0, 1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: pc=%h fv=%b fl=%b epc=%h mis=%b required pc=00003000 fv=0 fl=0 epc=00000000 mis=0",
               pcValue, fetchValid, flush, epcValue, misaligned);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({pcValue, fetchValid, flush} !== {32'h0000_3000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL boot_cycle: pc=%h fv=%b fl=%b required pc=00003000 fv=0 fl=0",
               pcValue, fetchValid, flush);
    end
    exp_q.push_back(exp_t'{32'h0000_3000, 1'b1, 1'b0});
    exp_q.push_back(exp_t'{32'h0000_3004, 1'b1, 1'b0});
    exp_q.push_back(exp_t'{32'h0000_3008, 1'b1, 1'b0});
    exp_q.push_back(exp_t'{32'h0000_300C, 1'b1, 1'b0});
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({pcValue, fetchValid, flush} !== {e.pc, e.fv, e.fl}) begin
        errors++;
        $display("FAIL reset_release: pc=%h fv=%b fl=%b required pc=%h fv=%b fl=%b",
                 pcValue, fetchValid, flush, e.pc, e.fv, e.fl);
      end
    end
  endtask

  task automatic test_stall();
    logic st [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_q.push_back(exp_t'{32'h0000_300C, 1'b0, 1'b0});
    exp_q.push_back(exp_t'{32'h0000_300C, 1'b0, 1'b0});
    exp_q.push_back(exp_t'{32'h0000_300C, 1'b0, 1'b0});
    exp_q.push_back(exp_t'{32'h0000_300C, 1'b1, 1'b0});
    exp_q.push_back(exp_t'{32'h0000_3010, 1'b1, 1'b0});
    for (int i = 0; i < 5; i++) begin
      stall = st[i];
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({pcValue, fetchValid, flush} !== {e.pc, e.fv, e.fl}) begin
        errors++;
        $display("FAIL stall_step%0d: pc=%h fv=%b fl=%b required pc=%h fv=%b fl=%b",
                 i, pcValue, fetchValid, flush, e.pc, e.fv, e.fl);
      end
    end
    clear_inputs();
  endtask

  task automatic test_exception();
    logic        ex  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic        er  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] epc_exp;
`ifdef PC_SEQ_EXCEPTION_EN
    epc_exp = 32'h0000_3010;
    exp_q.push_back(exp_t'{32'h0000_4180, 1'b1, 1'b1});
    exp_q.push_back(exp_t'{32'h0000_4184, 1'b1, 1'b0});
    exp_q.push_back(exp_t'{32'h0000_3010, 1'b1, 1'b1});
    exp_q.push_back(exp_t'{32'h0000_3014, 1'b1, 1'b0});
`else
    epc_exp = 32'h0000_0000;
    exp_q.push_back(exp_t'{32'h0000_3014, 1'b1, 1'b0});
    exp_q.push_back(exp_t'{32'h0000_3018, 1'b1, 1'b0});
    exp_q.push_back(exp_t'{32'h0000_301C, 1'b1, 1'b0});
    exp_q.push_back(exp_t'{32'h0000_3020, 1'b1, 1'b0});
`endif
    for (int i = 0; i < 4; i++) begin
      excReq = ex[i];
      eret   = er[i];
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({pcValue, fetchValid, flush} !== {e.pc, e.fv, e.fl}) begin
        errors++;
        $display("FAIL exc_step%0d: pc=%h fv=%b fl=%b required pc=%h fv=%b fl=%b",
                 i, pcValue, fetchValid, flush, e.pc, e.fv, e.fl);
      end
      checks++;
      if (epcValue !== epc_exp) begin
        errors++;
        $display("FAIL epc_step%0d: epc=%h required %h", i, epcValue, epc_exp);
      end
    end
    clear_inputs();
  endtask

  task automatic test_branch_jump();
    logic        bt [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic        je [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [25:0] ji [4] = '{26'h3FF_FFFF, 26'h0, 26'h000_1C00, 26'h0};
    exp_q.push_back(exp_t'{32'h0000_5000, 1'b1, 1'b1});
    exp_q.push_back(exp_t'{32'h0000_5004, 1'b1, 1'b0});
    exp_q.push_back(exp_t'{32'h0000_7000, 1'b1, 1'b1});
    exp_q.push_back(exp_t'{32'h0000_7004, 1'b1, 1'b0});
    branchTarget = 32'h0000_5000;
    for (int i = 0; i < 4; i++) begin
      branchTaken = bt[i];
      jumpEnabled = je[i];
      jumpIndex   = ji[i];
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({pcValue, fetchValid, flush} !== {e.pc, e.fv, e.fl}) begin
        errors++;
        $display("FAIL branch_jump_step%0d: pc=%h fv=%b fl=%b required pc=%h fv=%b fl=%b",
                 i, pcValue, fetchValid, flush, e.pc, e.fv, e.fl);
      end
    end
    checks++;
    if (misaligned !== 1'b0) begin
      errors++;
      $display("FAIL aligned_no_flag: misaligned=%b required 0", misaligned);
    end
    clear_inputs();
  endtask

  task automatic test_redirect_over_stall();
    logic st [3] = '{1'b1, 1'b1, 1'b0};
    logic bt [3] = '{1'b0, 1'b1, 1'b0};
    exp_q.push_back(exp_t'{32'h0000_7004, 1'b0, 1'b0});
    exp_q.push_back(exp_t'{32'h0000_8000, 1'b1, 1'b1});
    exp_q.push_back(exp_t'{32'h0000_8004, 1'b1, 1'b0});
    branchTarget = 32'h0000_8000;
    for (int i = 0; i < 3; i++) begin
      stall       = st[i];
      branchTaken = bt[i];
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({pcValue, fetchValid, flush} !== {e.pc, e.fv, e.fl}) begin
        errors++;
        $display("FAIL redirect_stall_step%0d: pc=%h fv=%b fl=%b required pc=%h fv=%b fl=%b",
                 i, pcValue, fetchValid, flush, e.pc, e.fv, e.fl);
      end
    end
    clear_inputs();
  endtask

  task automatic test_jump_region();
    logic bt [3] = '{1'b1, 1'b0, 1'b0};
    logic je [3] = '{1'b0, 1'b1, 1'b0};
    exp_q.push_back(exp_t'{32'hF000_0000, 1'b1, 1'b1});
    exp_q.push_back(exp_t'{32'hF000_0040, 1'b1, 1'b1});
    exp_q.push_back(exp_t'{32'hF000_0044, 1'b1, 1'b0});
    branchTarget = 32'hF000_0000;
    jumpIndex    = 26'h000_0010;
    for (int i = 0; i < 3; i++) begin
      branchTaken = bt[i];
      jumpEnabled = je[i];
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({pcValue, fetchValid, flush} !== {e.pc, e.fv, e.fl}) begin
        errors++;
        $display("FAIL jump_region_step%0d: pc=%h fv=%b fl=%b required pc=%h fv=%b fl=%b",
                 i, pcValue, fetchValid, flush, e.pc, e.fv, e.fl);
      end
    end
    clear_inputs();
  endtask

  task automatic test_misaligned();
    exp_q.push_back(exp_t'{32'h0000_6000, 1'b1, 1'b1});
    exp_q.push_back(exp_t'{32'h0000_6004, 1'b1, 1'b0});
    exp_q.push_back(exp_t'{32'h0000_6008, 1'b1, 1'b0});
    exp_q.push_back(exp_t'{32'h0000_600C, 1'b1, 1'b0});
    branchTarget = 32'h0000_6002;
    for (int i = 0; i < 4; i++) begin
      branchTaken = (i == 0);
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({pcValue, fetchValid, flush, misaligned} !== {e.pc, e.fv, e.fl, 1'b1}) begin
        errors++;
        $display("FAIL misaligned_step%0d: pc=%h fv=%b fl=%b mis=%b required pc=%h fv=%b fl=%b mis=1",
                 i, pcValue, fetchValid, flush, misaligned, e.pc, e.fv, e.fl);
      end
    end
    clear_inputs();
  endtask

  task automatic test_wrap();
    exp_q.push_back(exp_t'{32'hFFFF_FFF8, 1'b1, 1'b1});
    exp_q.push_back(exp_t'{32'hFFFF_FFFC, 1'b1, 1'b0});
    exp_q.push_back(exp_t'{32'h0000_0000, 1'b1, 1'b0});
    exp_q.push_back(exp_t'{32'h0000_0004, 1'b1, 1'b0});
    branchTarget = 32'hFFFF_FFF8;
    for (int i = 0; i < 4; i++) begin
      branchTaken = (i == 0);
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({pcValue, fetchValid, flush} !== {e.pc, e.fv, e.fl}) begin
        errors++;
        $display("FAIL wrap_step%0d: pc=%h fv=%b fl=%b required pc=%h fv=%b fl=%b",
                 i, pcValue, fetchValid, flush, e.pc, e.fv, e.fl);
      end
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    stall = 1'b1;
    tick();
    checks++;
    if ({pcValue, fetchValid, flush} !== {32'h0000_0004, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL hold_before_reset: pc=%h fv=%b fl=%b required pc=00000004 fv=0 fl=0",
               pcValue, fetchValid, flush);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({pcValue, fetchValid, flush, epcValue, misaligned} !==
        {32'h0000_3000, 1'b0, 1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: pc=%h fv=%b fl=%b epc=%h mis=%b required pc=00003000 fv=0 fl=0 epc=00000000 mis=0",
               pcValue, fetchValid, flush, epcValue, misaligned);
    end
    clear_inputs();
    #1;
    reset = 1'b1;
    exp_q.push_back(exp_t'{32'h0000_3000, 1'b1, 1'b0});
    exp_q.push_back(exp_t'{32'h0000_3004, 1'b1, 1'b0});
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({pcValue, fetchValid, flush} !== {e.pc, e.fv, e.fl}) begin
        errors++;
        $display("FAIL post_reset: pc=%h fv=%b fl=%b required pc=%h fv=%b fl=%b",
                 pcValue, fetchValid, flush, e.pc, e.fv, e.fl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_exception();
    test_branch_jump();
    test_redirect_over_stall();
    test_jump_region();
    test_misaligned();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
